// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
// No ports; imported by regfile_mp and rf_scoreboard.
package regfile_pkg;

  localparam int unsigned XLEN_D   = 32;
  localparam int unsigned NREGS_D  = 32;
  localparam int unsigned AW_D     = $clog2(NREGS_D);
  localparam int unsigned ZERO_REG = 0;

  typedef logic [AW_D-1:0]   reg_addr_t;
  typedef logic [XLEN_D-1:0] xword_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard for RAW hazard detection.
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   rsv_en, rsv_addr  reserve a destination (sets its busy bit)
//   we, wa            write-port enables/addresses (writeback clears busy)
//   busy              registered busy vector, bit 0 always 0
//   any_busy          OR of all busy bits
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS = NREGS_D,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              rsv_en,
  input  logic [AW-1:0]     rsv_addr,
  input  logic [NWR-1:0]    we,
  input  logic [NWR*AW-1:0] wa,
  output logic [NREGS-1:0]  busy,
  output logic              any_busy
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic [NREGS-1:0] clr;

  // A register is retired when any write port targets it this cycle.
  always_comb begin
    clr = '0;
    for (int r = 0; r < int'(NREGS); r++) begin
      for (int j = 0; j < int'(NWR); j++) begin
        if (we[j] && (wa[j*AW +: AW] == AW'(r))) clr[r] = 1'b1;
      end
    end
  end

  // Reserve beats clear: the new producer supersedes the retiring one.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < int'(NREGS); r++) begin
      if (rsv_en && (rsv_addr == AW'(r))) begin
        busy_d[r] = 1'b1;
      end else if (clr[r]) begin
        busy_d[r] = 1'b0;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign any_busy = |busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with busy scoreboard.
// Register 0 reads as zero and ignores writes; on a same-cycle address
// collision the highest-index write port wins.
// Optional macro RF_BYPASS_EN: reads forward same-cycle write data and
// report not-busy for the forwarded register.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   ra, rd         NRD combinational read ports (packed, port i at i*AW / i*XLEN)
//   rd_busy        busy bit of each read address
//   we, wa, wd     NWR clocked write ports
//   rsv_en/addr    reserve a destination register
//   any_busy       OR of all busy bits
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_D,
  parameter int unsigned NREGS = NREGS_D,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWR   = 2,
  localparam int unsigned AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  output logic                any_busy
);

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [XLEN-1:0]  rf_d [NREGS];
  logic [NREGS-1:0] busy;

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .reset_n  (reset_n),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .we       (we),
    .wa       (wa),
    .busy     (busy),
    .any_busy (any_busy)
  );

  // Ascending port scan so the highest-index port lands last and wins.
  always_comb begin
    for (int r = 0; r < int'(NREGS); r++) rf_d[r] = rf_q[r];
    for (int j = 0; j < int'(NWR); j++) begin
      if (we[j] && (wa[j*AW +: AW] != AW'(ZERO_REG))) begin
        rf_d[wa[j*AW +: AW]] = wd[j*XLEN +: XLEN];
      end
    end
    rf_d[ZERO_REG] = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < int'(NREGS); r++) rf_q[r] <= '0;
    end else begin
      for (int r = 0; r < int'(NREGS); r++) rf_q[r] <= rf_d[r];
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < int'(NRD); i++) begin
      if (ra[i*AW +: AW] != AW'(ZERO_REG)) begin
        rd[i*XLEN +: XLEN] = rf_q[ra[i*AW +: AW]];
        rd_busy[i]         = busy[ra[i*AW +: AW]];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < int'(NWR); j++) begin
          if (we[j] && (wa[j*AW +: AW] == ra[i*AW +: AW])) begin
            rd[i*XLEN +: XLEN] = wd[j*XLEN +: XLEN];
            rd_busy[i]         = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rd_busy;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        any_busy;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_mp dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra       (ra),
    .rd       (rd),
    .rd_busy  (rd_busy),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .any_busy (any_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        rsv;
    logic [4:0]  rsv_a;
    logic [4:0]  ra0, ra1;
    logic [31:0] e_rd0, e_rd1;
    logic        e_b0, e_b1, e_any;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    we       = v.we;
    wa       = {v.wa1, v.wa0};
    wd       = {v.wd1, v.wd0};
    rsv_en   = v.rsv;
    rsv_addr = v.rsv_a;
    ra       = {v.ra1, v.ra0};
  endtask

  task automatic check_outs(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                            input logic b0, input logic b1, input logic ba);
    chk({tag, " rd0"}, rd[31:0], e0);
    chk({tag, " rd1"}, rd[63:32], e1);
    chk({tag, " busy0"}, {31'd0, rd_busy[0]}, {31'd0, b0});
    chk({tag, " busy1"}, {31'd0, rd_busy[1]}, {31'd0, b1});
    chk({tag, " any_busy"}, {31'd0, any_busy}, {31'd0, ba});
  endtask

  initial begin
    // Outputs checked just before the edge that commits each vector, so the
    // expected values reflect state left by earlier vectors.
    //            we     wa0 wa1 wd0            wd1            rsv  ra   ra0 ra1 rd0                         rd1            b0   b1   any
    tbl[0]  = '{2'b01, 5,  0, 32'hDEADBEEF, 32'h0,         0, 0,  5,  0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0,         0,   0,   0};
    tbl[1]  = '{2'b00, 5,  5, 32'h13579BDF, 32'h2468ACE0,  0, 0,  5,  0, 32'hDEADBEEF,              32'h0,         0,   0,   0};
    tbl[2]  = '{2'b01, 0,  0, 32'hFFFFFFFF, 32'h0,         0, 0,  0,  5, 32'h0,                     32'hDEADBEEF,  0,   0,   0};
    tbl[3]  = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  0,  5, 32'h0,                     32'hDEADBEEF,  0,   0,   0};
    tbl[4]  = '{2'b11, 7,  7, 32'h11,       32'h22,        0, 0,  7,  5, BYP ? 32'h22 : 32'h0,      32'hDEADBEEF,  0,   0,   0};
    tbl[5]  = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  7,  0, 32'h22,                    32'h0,         0,   0,   0};
    tbl[6]  = '{2'b00, 0,  0, 32'h0,        32'h0,         1, 3,  3,  0, 32'h0,                     32'h0,         0,   0,   0};
    tbl[7]  = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  3,  0, 32'h0,                     32'h0,         1,   0,   1};
    tbl[8]  = '{2'b10, 0,  3, 32'h0,        32'h55,        0, 0,  3,  0, BYP ? 32'h55 : 32'h0,      32'h0,         !BYP, 0,  1};
    tbl[9]  = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  3,  0, 32'h55,                    32'h0,         0,   0,   0};
    tbl[10] = '{2'b01, 3,  0, 32'h66,       32'h0,         1, 3,  3,  0, BYP ? 32'h66 : 32'h55,     32'h0,         0,   0,   0};
    tbl[11] = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  3,  7, 32'h66,                    32'h22,        1,   0,   1};
    tbl[12] = '{2'b10, 0,  9, 32'h0,        32'hA5A5,      0, 0,  3,  9, 32'h66,                    BYP ? 32'hA5A5 : 32'h0, 1, 0, 1};
    tbl[13] = '{2'b00, 9,  9, 32'h0BAD,     32'h0BAD,      0, 0,  3,  9, 32'h66,                    32'hA5A5,      1,   0,   1};
    tbl[14] = '{2'b11, 3,  4, 32'h77,       32'h1234,      1, 4,  4,  3, BYP ? 32'h1234 : 32'h0,    BYP ? 32'h77 : 32'h66, 0, !BYP, 1};
    tbl[15] = '{2'b00, 0,  0, 32'h0,        32'h0,         0, 0,  4,  3, 32'h1234,                  32'h77,        1,   0,   1};

    // Reset held with random write traffic: everything reads zero.
    reset_n  = 1'b0;
    rsv_en   = 1'b0;
    rsv_addr = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      we       = 2'($urandom);
      wa       = 10'($urandom);
      wd       = {$urandom, $urandom};
      rsv_en   = 1'b1;
      rsv_addr = 5'($urandom_range(1, 31));
      ra       = {5'd7, 5'd5};
      #1;
      check_outs($sformatf("reset%0d", c), 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    reset_n = 1'b1;

    for (int k = 0; k < 16; k++) begin
      drive(tbl[k]);
      #1;
      check_outs($sformatf("v%0d", k), tbl[k].e_rd0, tbl[k].e_rd1, tbl[k].e_b0, tbl[k].e_b1,
                 tbl[k].e_any);
      @(negedge clk);
    end

    // Asynchronous reset between edges with r4 busy and holding 0x1234.
    we     = 2'b00;
    rsv_en = 1'b0;
    ra     = {5'd5, 5'd4};
    #2;
    check_outs("pre_areset", 32'h1234, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    check_outs("areset", 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;

    // Reserving r0 never sets busy; write after reset lands on the next edge.
    rsv_en   = 1'b1;
    rsv_addr = 5'd0;
    we       = 2'b01;
    wa       = {5'd0, 5'd5};
    wd       = {32'h0, 32'hCAFEF00D};
    @(negedge clk);
    rsv_en = 1'b0;
    we     = 2'b00;
    ra     = {5'd0, 5'd5};
    #1;
    check_outs("post_areset", 32'hCAFEF00D, 32'h0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
